// File: rtl/proc_mem_responder_pkg.sv
// ============================================================================
//  Module      : proc_mem_responder_pkg
//  Description : Memory message types, type codes and byte-lane helpers for
//                proc_mem_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_mem_responder_pkg;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    localparam logic [2:0] c_msg_type_read     = 3'd0;
    localparam logic [2:0] c_msg_type_write    = 3'd1;
    localparam logic [2:0] c_msg_type_init     = 3'd2;
    localparam logic [2:0] c_msg_type_amo_add  = 3'd3;
    localparam logic [2:0] c_msg_type_amo_and  = 3'd4;
    localparam logic [2:0] c_msg_type_amo_or   = 3'd5;
    localparam logic [2:0] c_msg_type_amo_swap = 3'd6;
    localparam logic [2:0] c_msg_type_amo_min  = 3'd7;

    // len encodes 0 as a full word; the mask covers the low len bytes
    function automatic logic [3:0] len_to_byte_mask(input logic [1:0] len);
        logic [3:0] mask;
        case (len)
            2'd1:    mask = 4'b0001;
            2'd2:    mask = 4'b0011;
            2'd3:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] byte_mask_to_bits(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/proc_mem_responder_rqueue.sv
// ============================================================================
//  Module      : proc_mem_responder_rqueue
//  Description : Parameterised-depth FIFO of mem_resp_4B_t; registered storage,
//                push and pop may coincide even when full.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_mem_responder_rqueue
    import proc_mem_responder_pkg::*;
#(
    parameter int p_depth = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enq_val,
    input  logic [$bits(mem_resp_4B_t)-1:0]  enq_msg,
    output logic                             deq_val,
    input  logic                             deq_rdy,
    output logic [$bits(mem_resp_4B_t)-1:0]  deq_msg
);

    localparam int c_ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int c_cnt_w = $clog2(p_depth + 1);

    logic [$bits(mem_resp_4B_t)-1:0] r_mem [p_depth];
    logic [c_ptr_w-1:0]              r_wr_ptr;
    logic [c_ptr_w-1:0]              r_rd_ptr;
    logic [c_cnt_w-1:0]              r_count;
    logic                            w_pop;

    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_w'(p_depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign deq_val = (r_count != '0);
    assign deq_msg = r_mem[r_rd_ptr];
    assign w_pop   = deq_val && deq_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (enq_val) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({enq_val, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // When full, a simultaneous pop frees the very slot being written
    always_ff @(posedge clk) begin
        if (enq_val) begin
            r_mem[r_wr_ptr] <= enq_msg;
        end
    end

endmodule

`default_nettype wire

// File: rtl/proc_mem_responder.sv
// ============================================================================
//  Module      : proc_mem_responder
//  Description : Single-port memory responder with fixed latency and a
//                credit-protected response queue. Optional AMO support is
//                enabled by defining PROC_MEM_RESPONDER_AMO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_mem_responder
    import proc_mem_responder_pkg::*;
#(
    parameter int p_num_words = 256,
    parameter int p_latency   = 1,
    parameter int p_q_depth   = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             reqstream_val,
    output logic                             reqstream_rdy,
    input  logic [$bits(mem_req_4B_t)-1:0]   reqstream_msg,
    output logic                             respstream_val,
    input  logic                             respstream_rdy,
    output logic [$bits(mem_resp_4B_t)-1:0]  respstream_msg
);

    localparam int c_idx_w  = $clog2(p_num_words);
    localparam int c_cred_w = $clog2(p_q_depth + 1);

    mem_req_4B_t          w_req;
    mem_resp_4B_t         w_resp;
    logic [31:0]          r_mem [p_num_words];
    logic [c_idx_w-1:0]   w_idx;
    logic [1:0]           w_off;
    logic [31:0]          w_old;
    logic [3:0]           w_len_mask;
    logic [3:0]           w_lane_mask;
    logic [31:0]          w_wdata;
    logic [31:0]          w_rdata;
    logic [31:0]          w_new_word;
    logic [31:0]          w_resp_data;
    logic                 w_do_write;
    logic                 w_fire;
    logic                 w_resp_fire;
    logic                 w_push_val;
    mem_resp_4B_t         w_push_msg;
    logic [c_cred_w-1:0]  r_credits;
    logic [c_cred_w-1:0]  w_cred_next;
    logic                 r_rdy;
    logic [31-2-c_idx_w:0] w_unused_addr;

    assign w_req         = mem_req_4B_t'(reqstream_msg);
    assign w_idx         = w_req.addr[2 +: c_idx_w];
    assign w_unused_addr = w_req.addr[31:2+c_idx_w];
    assign w_off         = w_req.addr[1:0];
    assign w_old         = r_mem[w_idx];
    assign w_len_mask    = len_to_byte_mask(w_req.len);
    // Lanes shifted past byte 3 fall off: accesses never cross a word
    assign w_lane_mask   = w_len_mask << w_off;
    assign w_wdata       = w_req.data << {w_off, 3'b000};
    assign w_rdata       = (w_old >> {w_off, 3'b000}) & byte_mask_to_bits(w_len_mask);

    assign w_fire        = reqstream_val && r_rdy;
    assign w_resp_fire   = respstream_val && respstream_rdy;
    assign reqstream_rdy = r_rdy;

    always_comb begin
        w_new_word  = w_old;
        w_do_write  = 1'b0;
        w_resp_data = '0;
        case (w_req.type_)
            c_msg_type_read: begin
                w_resp_data = w_rdata;
            end
            c_msg_type_write, c_msg_type_init: begin
                w_do_write = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (w_lane_mask[b]) begin
                        w_new_word[8*b +: 8] = w_wdata[8*b +: 8];
                    end
                end
            end
            default: begin
                w_resp_data = w_old;
`ifdef PROC_MEM_RESPONDER_AMO_EN
                w_do_write = 1'b1;
                case (w_req.type_)
                    c_msg_type_amo_add: w_new_word = w_old + w_req.data;
                    c_msg_type_amo_and: w_new_word = w_old & w_req.data;
                    c_msg_type_amo_or:  w_new_word = w_old | w_req.data;
                    c_msg_type_amo_min: w_new_word = ($signed(w_old) < $signed(w_req.data))
                                                     ? w_old : w_req.data;
                    default:            w_new_word = w_req.data;
                endcase
`else
                w_do_write = 1'b0;
`endif
            end
        endcase
    end

    always_comb begin
        w_resp        = '0;
        w_resp.type_  = w_req.type_;
        w_resp.opaque = w_req.opaque;
        w_resp.test   = 2'd0;
        w_resp.len    = w_req.len;
        w_resp.data   = w_resp_data;
    end

    // Array contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (w_fire && w_do_write) begin
            r_mem[w_idx] <= w_new_word;
        end
    end

    generate
        if (p_latency > 1) begin : g_stages
            logic [p_latency-2:0] r_val;
            mem_resp_4B_t         r_msg [p_latency-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_val <= '0;
                end else begin
                    r_val[0] <= w_fire;
                    for (int i = 1; i < p_latency - 1; i++) begin
                        r_val[i] <= r_val[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_msg[0] <= w_resp;
                for (int i = 1; i < p_latency - 1; i++) begin
                    r_msg[i] <= r_msg[i-1];
                end
            end

            assign w_push_val = r_val[p_latency-2];
            assign w_push_msg = r_msg[p_latency-2];
        end else begin : g_no_stages
            assign w_push_val = w_fire;
            assign w_push_msg = w_resp;
        end
    endgenerate

    proc_mem_responder_rqueue #(
        .p_depth (p_q_depth)
    ) u_rqueue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (w_push_val),
        .enq_msg (w_push_msg),
        .deq_val (respstream_val),
        .deq_rdy (respstream_rdy),
        .deq_msg (respstream_msg)
    );

    always_comb begin
        case ({w_fire, w_resp_fire})
            2'b10:   w_cred_next = r_credits + 1'b1;
            2'b01:   w_cred_next = r_credits - 1'b1;
            default: w_cred_next = r_credits;
        endcase
    end

    // Ready is a register of the next credit count, so it has no input-to-output path
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credits <= '0;
            r_rdy     <= 1'b0;
        end else begin
            r_credits <= w_cred_next;
            r_rdy     <= (w_cred_next < c_cred_w'(p_q_depth));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_proc_mem_responder.sv
// ============================================================================
//  Module      : tb_proc_mem_responder
//  Description : Self-checking bench for proc_mem_responder (latency 3, depth 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_mem_responder;
    import proc_mem_responder_pkg::*;

    localparam int c_lat   = 3;
    localparam int c_depth = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqstream_val;
    logic        reqstream_rdy;
    logic [76:0] reqstream_msg;
    logic        respstream_val;
    logic        respstream_rdy;
    logic [46:0] respstream_msg;

    proc_mem_responder #(
        .p_num_words (256),
        .p_latency   (c_lat),
        .p_q_depth   (c_depth)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .reqstream_val  (reqstream_val),
        .reqstream_rdy  (reqstream_rdy),
        .reqstream_msg  (reqstream_msg),
        .respstream_val (respstream_val),
        .respstream_rdy (respstream_rdy),
        .respstream_msg (respstream_msg)
    );

    always #5 clk = ~clk;

    typedef struct {
        mem_resp_4B_t msg;
        int           ready_cyc;
    } exp_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           n_fires  = 0;
    logic         check_en = 1'b0;
    logic         last_rst = 1'b1;
    logic [31:0]  model_mem [256];
    exp_t         expq[$];
    mem_resp_4B_t resp_log[$];
    int           resp_cyc[$];
    int           fire_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: byte-by-byte view of the word, independent of the RTL datapath
    function automatic mem_resp_4B_t model_op(input mem_req_4B_t r);
        mem_resp_4B_t o;
        int           idx = (r.addr >> 2) % 256;
        int           off = int'(r.addr[1:0]);
        int           n   = (r.len == 2'd0) ? 4 : int'(r.len);
        logic [31:0]  w   = model_mem[idx];
        logic [31:0]  d   = '0;
        case (r.type_)
            3'd0: begin
                for (int i = 0; i < n; i++)
                    if (off + i < 4) d[8*i +: 8] = w[8*(off+i) +: 8];
            end
            3'd1, 3'd2: begin
                for (int i = 0; i < n; i++)
                    if (off + i < 4) model_mem[idx][8*(off+i) +: 8] = r.data[8*i +: 8];
            end
            default: begin
                d = w;
`ifdef PROC_MEM_RESPONDER_AMO_EN
                case (r.type_)
                    3'd3:    model_mem[idx] = w + r.data;
                    3'd4:    model_mem[idx] = w & r.data;
                    3'd5:    model_mem[idx] = w | r.data;
                    3'd6:    model_mem[idx] = r.data;
                    default: model_mem[idx] = ($signed(r.data) < $signed(w)) ? r.data : w;
                endcase
`endif
            end
        endcase
        o.type_  = r.type_;
        o.opaque = r.opaque;
        o.test   = 2'd0;
        o.len    = r.len;
        o.data   = d;
        return o;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        last_rst <= reset;
    end

    // Compare process: check outputs against the model, then record this cycle's handshakes
    always @(negedge clk) begin
        if (check_en) begin
            check("reqstream_rdy", 64'(reqstream_rdy),
                  64'(!last_rst && (expq.size() < c_depth)));
            check("respstream_val", 64'(respstream_val),
                  64'(expq.size() > 0 && expq[0].ready_cyc <= cyc));
            if (respstream_val && expq.size() > 0 && expq[0].ready_cyc <= cyc)
                check("respstream_msg", 64'(respstream_msg), 64'(expq[0].msg));
            if (reset) begin
                expq.delete();
            end else begin
                if (respstream_val && respstream_rdy && expq.size() > 0) begin
                    resp_log.push_back(mem_resp_4B_t'(respstream_msg));
                    resp_cyc.push_back(cyc);
                    void'(expq.pop_front());
                end
                if (reqstream_val && reqstream_rdy) begin
                    exp_t e;
                    e.msg       = model_op(mem_req_4B_t'(reqstream_msg));
                    e.ready_cyc = cyc + c_lat;
                    expq.push_back(e);
                    fire_cyc.push_back(cyc);
                    n_fires++;
                end
            end
        end
    end

    task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                        input logic [1:0] l, input logic [31:0] d);
        mem_req_4B_t r;
        int          n = 0;
        r.type_ = t; r.opaque = op; r.addr = a; r.len = l; r.data = d;
        reqstream_msg = r;
        reqstream_val = 1'b1;
        forever begin
            @(negedge clk);
            if (reqstream_rdy) break;
            n++;
            if (n > 200) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: got no ready required ready within 200 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        reqstream_val = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending required 0", expq.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_last(input string name, input int back, input logic [31:0] exp);
        if (resp_log.size() <= back) begin
            n_checks++; n_fail++;
            $display("FAIL %s: got no response required %0h", name, exp);
        end else begin
            check(name, 64'(resp_log[resp_log.size()-1-back].data), 64'(exp));
        end
    endtask

    initial begin
        int f0, r0;
        reset          = 1'b1;
        reqstream_val  = 1'b0;
        reqstream_msg  = '0;
        respstream_rdy = 1'b1;
        @(posedge clk); #1;
        check_en = 1'b1;
        check("reset_rdy", 64'(reqstream_rdy), 64'd0);
        check("reset_val", 64'(respstream_val), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rdy_after_reset", 64'(reqstream_rdy), 64'd1);

        // Full-word write then read back
        send(3'd1, 8'h11, 32'h100, 2'd0, 32'hdeadbeef);
        send(3'd0, 8'h22, 32'h100, 2'd0, 32'h0);
        drain();
        check_last("write_resp_data", 1, 32'h0);
        check_last("read_deadbeef", 0, 32'hdeadbeef);
        check("read_type", 64'(resp_log[resp_log.size()-1].type_), 64'd0);
        check("read_opaque", 64'(resp_log[resp_log.size()-1].opaque), 64'h22);

        // Sub-word accesses, word boundary clipping, address wrap
        send(3'd0, 8'h23, 32'h101, 2'd1, 32'h0);
        drain();
        check_last("read_byte1", 0, 32'h000000be);
        send(3'd1, 8'h24, 32'h102, 2'd2, 32'hcafe1234);
        send(3'd0, 8'h25, 32'h100, 2'd0, 32'h0);
        drain();
        check_last("half_write", 0, 32'h1234beef);
        send(3'd0, 8'h26, 32'h103, 2'd3, 32'h0);
        send(3'd0, 8'h27, 32'h500, 2'd0, 32'h0);
        send(3'd0, 8'h28, 32'h102, 2'd0, 32'h0);
        drain();
        check_last("clip_read_len3", 2, 32'h00000012);
        check_last("wrap_read", 1, 32'h1234beef);
        check_last("clip_read_len0", 0, 32'h00001234);
        send(3'd1, 8'h29, 32'h102, 2'd3, 32'haabbccdd);
        send(3'd0, 8'h2a, 32'h100, 2'd0, 32'h0);
        drain();
        check_last("clip_write", 0, 32'hccddbeef);

        // Back-to-back reads at full rate
        for (int i = 0; i < 10; i++) send(3'd2, 8'(i), 32'h200 + 32'(4*i), 2'd0, 32'h1000 + 32'(i));
        drain();
        f0 = n_fires;
        r0 = resp_log.size();
        for (int i = 0; i < 10; i++) send(3'd0, 8'h40 + 8'(i), 32'h200 + 32'(4*i), 2'd0, 32'h0);
        drain();
        check("b2b_accept_span", 64'(fire_cyc[f0+9] - fire_cyc[f0]), 64'd9);
        check("b2b_first_latency", 64'(resp_cyc[r0] - fire_cyc[f0]), 64'd3);
        check("b2b_resp_span", 64'(resp_cyc[r0+9] - resp_cyc[r0]), 64'd9);
        check_last("b2b_last_data", 0, 32'h1009);

        // Response back-pressure
        respstream_rdy = 1'b0;
        f0 = n_fires;
        r0 = resp_log.size();
        fork
            begin
                for (int i = 0; i < 6; i++) send(3'd0, 8'h60 + 8'(i), 32'h200 + 32'(4*i), 2'd0, 32'h0);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                check("stall_fires", 64'(n_fires - f0), 64'(c_depth));
                check("stall_rdy_low", 64'(reqstream_rdy), 64'd0);
                respstream_rdy = 1'b1;
            end
        join
        drain();
        check("stall_resp_count", 64'(resp_log.size() - r0), 64'd6);
        check_last("stall_last_data", 0, 32'h1005);

        // Reset with requests in flight
        send(3'd0, 8'h70, 32'h200, 2'd0, 32'h0);
        send(3'd0, 8'h71, 32'h204, 2'd0, 32'h0);
        reset = 1'b1;
        r0 = resp_log.size();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("reset_drops", 64'(resp_log.size() - r0), 64'd0);
        send(3'd0, 8'h72, 32'h100, 2'd0, 32'h0);
        drain();
        check_last("array_persists", 0, 32'hccddbeef);

        // AMO add (acts as a read unless AMO support is built in)
        send(3'd1, 8'h80, 32'h300, 2'd0, 32'd5);
        send(3'd3, 8'h81, 32'h300, 2'd0, 32'd3);
        send(3'd0, 8'h82, 32'h300, 2'd0, 32'h0);
        drain();
        check_last("amo_old", 1, 32'd5);
`ifdef PROC_MEM_RESPONDER_AMO_EN
        check_last("amo_after", 0, 32'd8);
`else
        check_last("amo_after", 0, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
